sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clocks per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 1000: dead-time clocks at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 i_clk  in  1  system clock; one clock domain; all state on the rising edge.
REQ-004 i_reset  in  1  reset; synchronous, active-high.
REQ-005 i_en  in  1  display enable; low forces all anodes off while scanning continues.
REQ-006 i_d0, i_d1, i_d2, i_d3  in  4 each  BCD digits from upstream decade counters; i_d0 is least significant.
REQ-007 i_dp  in  4  decimal point per digit; bit n belongs to digit n; 1 means lit.
REQ-008 i_lzb  in  1  leading-zero blanking enable.
REQ-009 o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 o_dp  out  1  decimal point, active-low.
REQ-011 o_an  out  4  digit anodes, active-low; bit n selects digit n.
REQ-012 o_frame  out  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 Edge numbering: edge 1 is the first rising edge with i_reset low; slot s covers edges s*SCAN_DIV+1 .. (s+1)*SCAN_DIV; offset = edge - s*SCAN_DIV, range 1..SCAN_DIV.
REQ-015 Digit index SHALL be s mod 4, ascending 0,1,2,3, then wrapping to 0.
REQ-016 Offsets 1..BLANK_CYC: o_an=4'b1111, o_seg=7'h7F, o_dp=1 (dead time, anti-ghosting).
REQ-017 Offsets BLANK_CYC+1..SCAN_DIV: o_an drives only the indexed bit low, provided i_en=1 and the digit is not blanked; o_seg and o_dp show the indexed snapshot digit.
REQ-018 Blanked or disabled digit: o_an=4'b1111, o_seg=7'h7F, o_dp=1.
REQ-019 Active-low segment codes: 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10; codes 10..15 display 3F (segment g only).
REQ-020 o_dp SHALL be the inverse of the snapshot i_dp bit for the indexed digit.
REQ-021 Snapshot: at the edge with digit index 3 and offset SCAN_DIV, the block latches i_d0..i_d3, i_dp and i_lzb; o_frame=1 for exactly the following cycle.
REQ-022 The displayed data SHALL change only at frame boundaries, so mid-frame input changes cause no tearing.
REQ-023 Leading-zero blanking (snapshot i_lzb=1): digit n in 3..1 is blanked when its value and the values of all higher digits are 0.
REQ-024 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-025 A digit whose decimal point is set SHALL not be blanked, and neither SHALL any lower digit.
REQ-026 i_en is sampled every cycle, not snapshotted, and SHALL NOT affect slot timing, digit index or snapshot timing.
REQ-027 Slot counter and index wrap silently; no overflow state exists.

Reset
REQ-028 While i_reset=1: slot counter and digit index are 0; o_an=4'b1111, o_seg=7'h7F, o_dp=1, o_frame=0.
REQ-029 While i_reset=1 the snapshot SHALL load from the inputs every cycle, so frame 0 shows the inputs present at the last reset cycle.
REQ-030 Reset asserted mid-slot or mid-frame SHALL take effect at the next edge, and timing SHALL restart at edge 1 on release.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-031 Reset with d3..d0=1,2,3,4, i_en=1, i_lzb=0, i_dp=0 -> edges 1-2: o_an=1111; edges 3-8: o_an=1110, o_seg=19; edges 11-16: o_an=1101, o_seg=30; digits 2 and 3 follow the same pattern.
REQ-032 d3..d0=0,0,5,0, i_lzb=1 -> digits 3 and 2 show o_an=1111 for their whole slot; digit 1 shows 12; digit 0 shows 40.
REQ-033 Same as REQ-032 but i_dp=4'b1000 -> digit 3 shows 40 with o_dp=0; digit 2 shows 40 (not blanked).
REQ-034 Change i_d0 from 4 to 7 at edge 10 -> digit 0 keeps 19 until after edge 32; o_frame=1 for the one cycle after edge 32; the next slot-0 display (edges 35-40) shows 78.
REQ-035 i_d1=12 -> digit 1 shows 3F; drive i_en=0 during edges 11-16 -> o_an=1111 there, and digit 2 still starts at edge 17.
REQ-036 Assert i_reset at edge 13 for 3 cycles -> outputs idle during reset; the first active anode after release is digit 0 at release edge 3.

Source files
------------

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a 4-digit common-anode
// seven-segment display.
//
// Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYC clocks of
// every slot are dead time with everything off, which prevents ghosting
// while the anodes switch. The displayed data comes from a snapshot. The
// snapshot is taken once per frame, at the last clock of the digit-3 slot,
// so the display never shows a mix of two input states.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_en           display enable, sampled every cycle (not snapshotted)
//   i_d0..i_d3     BCD digits, i_d0 least significant
//   i_dp[3:0]      decimal point per digit, 1 = lit
//   i_lzb          leading-zero blanking enable
//   o_seg[6:0]     segments {g,f,e,d,c,b,a}, active-low
//   o_dp           decimal point, active-low
//   o_an[3:0]      digit anodes, active-low, bit n = digit n
//   o_frame        one-cycle pulse after a snapshot is taken
module sevenseg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [3:0] i_d0,
    input  logic [3:0] i_d1,
    input  logic [3:0] i_d2,
    input  logic [3:0] i_d3,
    input  logic [3:0] i_dp,
    input  logic       i_lzb,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [3:0] o_an,
    output logic       o_frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    // cnt_q counts the clocks already spent in the current slot
    // (0..SCAN_DIV-1). The slot offset of the edge being processed is
    // therefore cnt_q + 1.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      digits_q, digits_d;   // {d3,d2,d1,d0} snapshot
    logic [3:0]       dps_q, dps_d;
    logic             lzb_q, lzb_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_q, frame_d;

    logic [3:0]       blank;
    logic             zero_run;
    logic             slot_last;
    logic             snap_take;
    logic [3:0]       cur_digit;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;  // non-BCD: dash (segment g only)
        endcase
    endfunction

    // Leading-zero blanking. Walk from the top digit down. The run stays
    // alive only while digits are zero and have no decimal point, so a lit
    // decimal point also protects every lower digit. Digit 0 is never blanked.
    always_comb begin
        blank    = '0;
        zero_run = lzb_q;
        for (int n = 3; n >= 1; n--) begin
            zero_run = zero_run & (digits_q[n*4 +: 4] == 4'd0) & ~dps_q[n];
            blank[n] = zero_run;
        end
    end

    always_comb begin
        slot_last = (cnt_q == CNT_LAST);
        snap_take = slot_last && (idx_q == 2'd3);

        cnt_d = slot_last ? '0 : cnt_q + 1'b1;
        idx_d = slot_last ? idx_q + 2'd1 : idx_q;

        digits_d = digits_q;
        dps_d    = dps_q;
        lzb_d    = lzb_q;
        if (snap_take) begin
            digits_d = {i_d3, i_d2, i_d1, i_d0};
            dps_d    = i_dp;
            lzb_d    = i_lzb;
        end
        frame_d = snap_take;

        // The display uses the snapshot held before this edge, so the new
        // frame first appears in the digit-0 slot that follows.
        cur_digit = digits_q[{idx_q, 2'b00} +: 4];
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        // Offset cnt_q+1 is past the dead time when cnt_q >= BLANK_CYC.
        if (cnt_q >= CNT_BLANK && i_en && !blank[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_code(cur_digit);
            dp_d  = ~dps_q[idx_q];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            // Keep tracking the inputs during reset so frame 0 shows the
            // values present at the last reset cycle.
            digits_q <= {i_d3, i_d2, i_d1, i_d0};
            dps_q    <= i_dp;
            lzb_q    <= i_lzb;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            dps_q    <= dps_d;
            lzb_q    <= lzb_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            frame_q  <= frame_d;
        end
    end

    assign o_an    = an_q;
    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan with SCAN_DIV=8, BLANK_CYC=2.
// A reference model computes the expected outputs for each edge. It counts
// edges since reset release and derives the slot, offset and digit from that
// count. Each expectation is pushed to a queue when the inputs for that edge
// are driven. It is popped and compared one time unit after the edge.
module tb_sevenseg_scan;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       i_reset, i_en, i_lzb;
    logic [3:0] i_d0, i_d1, i_d2, i_d3, i_dp;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [3:0] o_an;
    logic       o_frame;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_e = 0;
    logic [3:0] m_d [4];
    logic [3:0] m_dp;
    logic       m_lzb;
    logic [12:0] exp_q [$];

    sevenseg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .i_d0    (i_d0),
        .i_d1    (i_d1),
        .i_d2    (i_d2),
        .i_d3    (i_d3),
        .i_dp    (i_dp),
        .i_lzb   (i_lzb),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_an    (o_an),
        .o_frame (o_frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d act=%h exp=%h", tag, m_e, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: ref_seg = 7'h40;  4'd1: ref_seg = 7'h79;
            4'd2: ref_seg = 7'h24;  4'd3: ref_seg = 7'h30;
            4'd4: ref_seg = 7'h19;  4'd5: ref_seg = 7'h12;
            4'd6: ref_seg = 7'h02;  4'd7: ref_seg = 7'h78;
            4'd8: ref_seg = 7'h00;  4'd9: ref_seg = 7'h10;
            default: ref_seg = 7'h3F;
        endcase
    endfunction

    // Digit n is blanked if it is not digit 0 and every digit k >= n is
    // zero with its decimal point off.
    function automatic logic ref_blank(input int n);
        logic b;
        b = m_lzb && (n > 0);
        for (int k = n; k <= 3; k++)
            if (m_d[k] != 4'd0 || m_dp[k]) b = 1'b0;
        return b;
    endfunction

    task automatic tick();
        logic [12:0] exp;
        logic [12:0] got;
        int s, off, idx;
        logic [3:0] an;
        logic fr;
        exp = {4'b1111, 7'h7F, 1'b1, 1'b0};
        if (i_reset) begin
            m_e = 0;
            m_d[0] = i_d0; m_d[1] = i_d1; m_d[2] = i_d2; m_d[3] = i_d3;
            m_dp = i_dp; m_lzb = i_lzb;
        end else begin
            m_e++;
            s   = (m_e - 1) / SD;
            off = m_e - s * SD;
            idx = s % 4;
            fr  = (idx == 3) && (off == SD);
            case (idx)
                0: an = 4'b1110;
                1: an = 4'b1101;
                2: an = 4'b1011;
                default: an = 4'b0111;
            endcase
            if (off > BC && i_en && !ref_blank(idx))
                exp = {an, ref_seg(m_d[idx]), ~m_dp[idx], fr};
            else
                exp = {4'b1111, 7'h7F, 1'b1, fr};
            if (fr) begin
                m_d[0] = i_d0; m_d[1] = i_d1; m_d[2] = i_d2; m_d[3] = i_d3;
                m_dp = i_dp; m_lzb = i_lzb;
            end
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_eq("out", {19'd0, o_an, o_seg, o_dp, o_frame}, {19'd0, got});
    endtask

    task automatic set_in(input logic [3:0] d3, d2, d1, d0, dp, input logic lzb, en);
        i_d3 = d3; i_d2 = d2; i_d1 = d1; i_d0 = d0;
        i_dp = dp; i_lzb = lzb; i_en = en;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0, 1'b1);
        #1;

        // basic scan, mid-frame input change held off until the frame boundary
        do_reset();
        check_eq("rst_an", {28'd0, o_an}, 32'hF);
        check_eq("rst_frame", {31'd0, o_frame}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            if (m_e == 9) i_d0 = 4'd7;
            tick();
            if (m_e == 2)  check_eq("dead_an", {28'd0, o_an}, 32'hF);
            if (m_e == 3)  check_eq("d0_seg", {25'd0, o_seg}, 32'h19);
            if (m_e == 3)  check_eq("d0_an", {28'd0, o_an}, 32'hE);
            if (m_e == 11) check_eq("d1_seg", {25'd0, o_seg}, 32'h30);
            if (m_e == 16) check_eq("d0_hold", {31'd0, o_frame}, 32'd0);
            if (m_e == 32) check_eq("frame", {31'd0, o_frame}, 32'd1);
            if (m_e == 35) check_eq("new_d0", {25'd0, o_seg}, 32'h78);
        end

        // leading-zero blanking
        set_in(4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (m_e == 3)  check_eq("lzb_d0", {25'd0, o_seg}, 32'h40);
            if (m_e == 11) check_eq("lzb_d1", {25'd0, o_seg}, 32'h12);
            if (m_e == 19) check_eq("lzb_d2", {28'd0, o_an}, 32'hF);
            if (m_e == 27) check_eq("lzb_d3", {28'd0, o_an}, 32'hF);
        end

        // decimal point stops blanking for its digit and all lower ones
        set_in(4'd0, 4'd0, 4'd5, 4'd0, 4'b1000, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (m_e == 19) check_eq("dp_d2", {25'd0, o_seg}, 32'h40);
            if (m_e == 27) check_eq("dp_d3", {25'd0, o_seg}, 32'h40);
            if (m_e == 27) check_eq("dp_bit", {31'd0, o_dp}, 32'd0);
        end

        // non-BCD code and enable gating
        set_in(4'd1, 4'd2, 4'd12, 4'd4, 4'd0, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 48; k++) begin
            if (m_e == 10) i_en = 1'b0;
            if (m_e == 16) i_en = 1'b1;
            tick();
            if (m_e == 13) check_eq("en_off", {28'd0, o_an}, 32'hF);
            if (m_e == 19) check_eq("en_d2", {28'd0, o_an}, 32'hB);
            if (m_e == 43) check_eq("dash", {25'd0, o_seg}, 32'h3F);
        end

        // reset mid-slot: asserted at edge 13 for 3 cycles
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 12; k++) tick();
        i_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("midrst_an", {28'd0, o_an}, 32'hF);
        end
        i_reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_e == 2) check_eq("rel_dead", {28'd0, o_an}, 32'hF);
            if (m_e == 3) check_eq("rel_d0", {28'd0, o_an}, 32'hE);
        end

        // random inputs, zeros favoured to exercise blanking
        do_reset();
        for (int k = 0; k < 160; k++) begin
            i_d0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            i_d1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            i_d2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            i_d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            i_dp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            i_lzb = ($urandom_range(0, 3) != 0);
            i_en  = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
